baud_gen_frac: RTL and testbench

Programmable fractional baud-rate generator for the UART transmit and receive paths. From one system clock it produces an oversample tick (`os_tick`), a 1× bit tick (`bit_tick`) and a mid-bit tick (`mid_tick`). The divisor is runtime-loadable with a fractional part, which keeps baud error low at any clock/baud ratio. A `sync_clr` input lets the receiver re-phase the generator on a detected start-bit edge.

---
 rtl/baud_gen_frac_if.sv | 32 +++
 rtl/baud_gen_frac.sv | 198 +++++++++++++++++++
 tb/tb_baud_gen_frac.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_gen_frac_if.sv
// Control/status bundle for the fractional baud-rate generator.
// The master side (UART control logic) drives the divisor and phase controls;
// the slave side (the generator) returns the tick stream and config status.
interface baud_gen_frac_if #(
  parameter int DIV_WIDTH = 16,
  parameter int FRAC_BITS = 4,
  parameter int SMP_RATE  = 16
);
  localparam int PH_W = $clog2(SMP_RATE);

  logic                 en;
  logic [DIV_WIDTH-1:0] div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 div_load;
  logic                 sync_clr;
  logic                 os_tick;
  logic                 bit_tick;
  logic                 mid_tick;
  logic [PH_W-1:0]      os_phase;
  logic                 cfg_pending;
  logic                 cfg_err;

  modport master (
    output en, div_int, div_frac, div_load, sync_clr,
    input  os_tick, bit_tick, mid_tick, os_phase, cfg_pending, cfg_err
  );

  modport slave (
    input  en, div_int, div_frac, div_load, sync_clr,
    output os_tick, bit_tick, mid_tick, os_phase, cfg_pending, cfg_err
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: produces an oversample tick whose average
// period is act_int + act_frac/2^FRAC_BITS clocks, plus bit and mid-bit ticks
// derived from the oversample phase. The divisor is loaded through a pending
// register and only takes effect on a period boundary or on sync_clr, so a
// period in progress is never cut short.
module baud_gen_frac #(
  parameter longint unsigned SYS_CLK   = 100000000,
  parameter longint unsigned BAUD_RATE = 9600,
  parameter int              SMP_RATE  = 16,
  parameter int              DIV_WIDTH = 16,
  parameter int              FRAC_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  baud_gen_frac_if.slave  bus
);

  localparam int PH_W = $clog2(SMP_RATE);

  // Reset-default divisor, computed in 64-bit so SYS_CLK << FRAC_BITS cannot overflow.
  localparam longint unsigned DEF_DEN   = BAUD_RATE * longint'(SMP_RATE);
  localparam longint unsigned DEF_INT_L = SYS_CLK / DEF_DEN;
  localparam longint unsigned DEF_FIX_L = (SYS_CLK << FRAC_BITS) / DEF_DEN;
  localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_INT_L);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_FIX_L);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SMP_RATE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(SMP_RATE / 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] cnt_reg,       cnt_next;
  logic [FRAC_BITS-1:0] acc_reg,       acc_next;
  logic                 ext_reg,       ext_next;
  logic [PH_W-1:0]      phase_reg,     phase_next;
  logic                 os_tick_reg,   os_tick_next;
  logic                 bit_tick_reg,  bit_tick_next;
  logic                 mid_tick_reg,  mid_tick_next;

  logic [DIV_WIDTH-1:0] act_int_reg,   act_int_next;
  logic [FRAC_BITS-1:0] act_frac_reg,  act_frac_next;
  logic [DIV_WIDTH-1:0] pend_int_reg,  pend_int_next;
  logic [FRAC_BITS-1:0] pend_frac_reg, pend_frac_next;
  logic                 pend_reg,      pend_next;
  logic                 err_reg,       err_next;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic                 load_ok;
  logic [DIV_WIDTH:0]   period_m1;
  logic                 at_end;
  logic                 wrap;
  logic [FRAC_BITS:0]   acc_sum;
  logic [PH_W-1:0]      phase_inc;

  // A load is only accepted when the divisor is at least 2 clocks.
  assign load_ok = bus.div_load && (bus.div_int >= DIV_WIDTH'(2));

  // Current period is act_int plus the fractional carry stored for it; one
  // extra bit so act_int = 2^DIV_WIDTH-1 with a carry still compares correctly.
  assign period_m1 = {1'b0, act_int_reg} + {{DIV_WIDTH{1'b0}}, ext_reg}
                   - (DIV_WIDTH + 1)'(1);
  assign at_end    = ({1'b0, cnt_reg} == period_m1);

  // sync_clr outranks counting, and nothing advances while en is low.
  assign wrap      = bus.en && !bus.sync_clr && at_end;

  // The carry out of this sum lengthens the next period by one clock.
  assign acc_sum   = {1'b0, acc_reg} + {1'b0, act_frac_reg};
  assign phase_inc = phase_reg + PH_W'(1);

  // ---------------------------------------------------------------------------
  // Period counter, fractional accumulator, oversample phase and tick pulses
  // ---------------------------------------------------------------------------
  // Next-state for the tick datapath; ticks default low so they are single-cycle.
  always_comb begin
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    ext_next      = ext_reg;
    phase_next    = phase_reg;
    os_tick_next  = 1'b0;
    bit_tick_next = 1'b0;
    mid_tick_next = 1'b0;

    if (bus.sync_clr) begin
      cnt_next   = '0;
      acc_next   = '0;
      ext_next   = 1'b0;
      phase_next = '0;
    end else if (bus.en) begin
      if (at_end) begin
        cnt_next              = '0;
        {ext_next, acc_next}  = acc_sum;
        phase_next            = phase_inc;
        os_tick_next          = 1'b1;
        bit_tick_next         = (phase_reg == PH_LAST);
        mid_tick_next         = (phase_inc == PH_MID);
      end else begin
        cnt_next = cnt_reg + DIV_WIDTH'(1);
      end
    end
  end

  // Register the tick datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      ext_reg      <= 1'b0;
      phase_reg    <= '0;
      os_tick_reg  <= 1'b0;
      bit_tick_reg <= 1'b0;
      mid_tick_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      ext_reg      <= ext_next;
      phase_reg    <= phase_next;
      os_tick_reg  <= os_tick_next;
      bit_tick_reg <= bit_tick_next;
      mid_tick_reg <= mid_tick_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Divisor configuration: pending capture and deferred apply
  // ---------------------------------------------------------------------------
  // Next-state for the divisor registers. On sync_clr a divisor presented the
  // same cycle wins over an older pending one; on a wrap the pending divisor is
  // applied first and a load in that same cycle becomes the new pending value.
  always_comb begin
    act_int_next   = act_int_reg;
    act_frac_next  = act_frac_reg;
    pend_int_next  = pend_int_reg;
    pend_frac_next = pend_frac_reg;
    pend_next      = pend_reg;
    err_next       = err_reg;

    if (bus.sync_clr) begin
      if (load_ok) begin
        act_int_next  = bus.div_int;
        act_frac_next = bus.div_frac;
      end else if (pend_reg) begin
        act_int_next  = pend_int_reg;
        act_frac_next = pend_frac_reg;
      end
      pend_next = 1'b0;
    end else begin
      if (wrap && pend_reg) begin
        act_int_next  = pend_int_reg;
        act_frac_next = pend_frac_reg;
        pend_next     = 1'b0;
      end
      if (load_ok) begin
        pend_int_next  = bus.div_int;
        pend_frac_next = bus.div_frac;
        pend_next      = 1'b1;
      end
    end

    // Status reflects the most recent load attempt, good or bad.
    if (bus.div_load) begin
      err_next = !load_ok;
    end
  end

  // Register the divisor configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_reg   <= DEF_INT;
      act_frac_reg  <= DEF_FRAC;
      pend_int_reg  <= DEF_INT;
      pend_frac_reg <= DEF_FRAC;
      pend_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      act_int_reg   <= act_int_next;
      act_frac_reg  <= act_frac_next;
      pend_int_reg  <= pend_int_next;
      pend_frac_reg <= pend_frac_next;
      pend_reg      <= pend_next;
      err_reg       <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are driven straight from registers
  // ---------------------------------------------------------------------------
  assign bus.os_tick     = os_tick_reg;
  assign bus.bit_tick    = bit_tick_reg;
  assign bus.mid_tick    = mid_tick_reg;
  assign bus.os_phase    = phase_reg;
  assign bus.cfg_pending = pend_reg;
  assign bus.cfg_err     = err_reg;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_baud_gen_frac;

  localparam int DW    = 16;
  localparam int FB    = 4;
  localparam int SMP   = 16;
  localparam int SCALE = 1 << FB;
  localparam int DEF_INT  = 1600 / (25 * SMP);
  localparam int DEF_FRAC = ((1600 * SCALE) / (25 * SMP)) % SCALE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  baud_gen_frac_if #(.DIV_WIDTH(DW), .FRAC_BITS(FB), .SMP_RATE(SMP)) bus ();

  baud_gen_frac #(
    .SYS_CLK(1600), .BAUD_RATE(25), .SMP_RATE(SMP),
    .DIV_WIDTH(DW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model: a period is a count of remaining enabled cycles; the
  // fractional part is kept as an unbounded running sum of fraction units.
  int     m_int, m_frac, m_pint, m_pfrac;
  bit     m_pend, m_err;
  int     m_len, m_left;
  longint m_fsum;
  int     m_phase;
  bit     m_os, m_bit, m_mid;

  task automatic model_step();
    bit load_ok;
    bit carry;
    load_ok = bus.div_load && (int'(bus.div_int) >= 2);
    if (rst) begin
      m_int = DEF_INT; m_frac = DEF_FRAC; m_pint = DEF_INT; m_pfrac = DEF_FRAC;
      m_pend = 0; m_err = 0; m_fsum = 0; m_phase = 0;
      m_len = DEF_INT; m_left = DEF_INT;
      m_os = 0; m_bit = 0; m_mid = 0;
    end else begin
      m_os = 0; m_bit = 0; m_mid = 0;
      if (bus.sync_clr) begin
        if (load_ok) begin
          m_int = int'(bus.div_int); m_frac = int'(bus.div_frac);
        end else if (m_pend) begin
          m_int = m_pint; m_frac = m_pfrac;
        end
        m_pend = 0; m_fsum = 0; m_phase = 0;
        m_len = m_int; m_left = m_int;
      end else begin
        if (bus.en) begin
          if (m_left == 1) begin
            carry  = ((m_fsum % SCALE) + m_frac) >= SCALE;
            m_fsum = m_fsum + m_frac;
            m_os   = 1;
            m_bit  = (m_phase == SMP - 1);
            m_phase = (m_phase + 1) % SMP;
            m_mid  = (m_phase == SMP / 2);
            if (m_pend) begin
              m_int = m_pint; m_frac = m_pfrac; m_pend = 0;
            end
            m_len  = m_int + int'(carry);
            m_left = m_len;
          end else begin
            m_left--;
          end
        end
        if (load_ok) begin
          m_pint = int'(bus.div_int); m_pfrac = int'(bus.div_frac); m_pend = 1;
        end
      end
      if (bus.div_load) m_err = !load_ok;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("os_tick",     32'(bus.os_tick),     32'(m_os));
    chk("bit_tick",    32'(bus.bit_tick),    32'(m_bit));
    chk("mid_tick",    32'(bus.mid_tick),    32'(m_mid));
    chk("os_phase",    32'(bus.os_phase),    32'(m_phase));
    chk("cfg_pending", 32'(bus.cfg_pending), 32'(m_pend));
    chk("cfg_err",     32'(bus.cfg_err),     32'(m_err));
  endtask

  task automatic run_until_tick(input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.os_tick && n < limit);
    if (!bus.os_tick) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tick_timeout: observed no os_tick within %0d cycles, required one", limit);
    end
  endtask

  initial begin
    int first_os, mid_at, bit_edge, nt, n, span, g;
    bus.en = 1'b0; bus.div_int = '0; bus.div_frac = '0;
    bus.div_load = 1'b0; bus.sync_clr = 1'b0;
    rst = 1'b1;
    cycle(); cycle();
    chk("reset_os_phase", 32'(bus.os_phase), 0);
    chk("reset_cfg_pending", 32'(bus.cfg_pending), 0);

    // Reset default divisor of 4: ticks at edges 4, 8, ...; mid with the 8th, bit at edge 64.
    rst = 1'b0; bus.en = 1'b1; cyc = 0;
    first_os = -1; mid_at = -1; bit_edge = -1; nt = 0;
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (bus.os_tick) begin
        nt++;
        if (first_os < 0) first_os = cyc;
      end
      if (bus.mid_tick && mid_at < 0) mid_at = nt;
      if (bus.bit_tick && bit_edge < 0) bit_edge = cyc;
    end
    chk("first_os_edge", 32'(first_os), 4);
    chk("first_mid_os_index", 32'(mid_at), 8);
    chk("first_bit_edge", 32'(bit_edge), 64);

    // Fractional divisor 4 + 8/16: first 16 ticks after the clear span 71 cycles.
    bus.div_int = 16'd4; bus.div_frac = 4'd8; bus.div_load = 1'b1;
    cycle();
    bus.div_load = 1'b0;
    cycle();
    bus.sync_clr = 1'b1;
    cycle();
    bus.sync_clr = 1'b0;
    n = 0; nt = 0;
    while (nt < 16 && n < 300) begin
      cycle();
      n++;
      if (bus.os_tick) nt++;
    end
    chk("frac_span16", 32'(n), 71);

    // Back to integer 4 via simultaneous load + clear, then reload 10 mid-period.
    bus.div_int = 16'd4; bus.div_frac = 4'd0; bus.div_load = 1'b1; bus.sync_clr = 1'b1;
    cycle();
    bus.div_load = 1'b0; bus.sync_clr = 1'b0;
    run_until_tick(50, g);
    chk("simul_load_clr_period", 32'(g), 4);
    cycle(); cycle();
    bus.div_int = 16'd10; bus.div_load = 1'b1;
    cycle();
    bus.div_load = 1'b0;
    chk("reload_pending", 32'(bus.cfg_pending), 1);
    run_until_tick(50, g);
    chk("reload_current_period_rest", 32'(g), 1);
    chk("reload_pending_cleared", 32'(bus.cfg_pending), 0);
    run_until_tick(50, g);
    chk("reload_new_period", 32'(g), 10);

    // Invalid load: error flag set, period unchanged; a valid load clears it.
    bus.div_int = 16'd1; bus.div_load = 1'b1;
    cycle();
    bus.div_load = 1'b0;
    chk("invalid_cfg_err", 32'(bus.cfg_err), 1);
    chk("invalid_no_pending", 32'(bus.cfg_pending), 0);
    run_until_tick(50, g);
    run_until_tick(50, g);
    chk("invalid_period_kept", 32'(g), 10);
    bus.div_int = 16'd4; bus.div_load = 1'b1;
    cycle();
    bus.div_load = 1'b0;
    chk("valid_clears_err", 32'(bus.cfg_err), 0);

    // Phase resync at os_phase 11, count 2.
    n = 0;
    while (!(m_phase == 11 && (m_len - m_left) == 2 && m_int == 4) && n < 1000) begin
      cycle();
      n++;
    end
    chk("resync_reached_point", 32'(m_phase), 11);
    bus.sync_clr = 1'b1;
    cycle();
    bus.sync_clr = 1'b0;
    chk("resync_phase_zero", 32'(bus.os_phase), 0);
    run_until_tick(50, g);
    chk("resync_first_gap", 32'(g), 4);
    nt = 1;
    while (!bus.mid_tick && nt < 40) begin
      run_until_tick(50, g);
      nt++;
    end
    chk("resync_mid_os_index", 32'(nt), 8);

    // Enable low for 7 cycles mid-period delays the stream by exactly 7.
    run_until_tick(50, g);
    cycle();
    bus.en = 1'b0;
    nt = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (bus.os_tick) nt++;
    end
    chk("en_low_no_ticks", 32'(nt), 0);
    bus.en = 1'b1;
    run_until_tick(50, g);
    chk("en_resume_gap", 32'(g), 3);

    // Reset mid-bit with a divisor pending: everything returns to defaults.
    for (int i = 0; i < 21; i++) cycle();
    bus.div_int = 16'd7; bus.div_load = 1'b1;
    cycle();
    bus.div_load = 1'b0;
    rst = 1'b1;
    cycle();
    chk("rst_pending_dropped", 32'(bus.cfg_pending), 0);
    chk("rst_phase", 32'(bus.os_phase), 0);
    rst = 1'b0;
    run_until_tick(50, g);
    chk("rst_default_period", 32'(g), DEF_INT);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.div_load = ($urandom_range(0, 29) == 0);
      bus.div_int  = 16'($urandom_range(0, 9));
      bus.div_frac = 4'($urandom_range(0, 15));
      bus.sync_clr = ($urandom_range(0, 99) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; bus.div_load = 1'b0; bus.sync_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
